fetch_mar_ir: RTL and testbench
===============================

Name: fetch_mar_ir

Overview:
Parametrised instruction-fetch register unit combining a multi-beat Instruction Register (IR) and a Memory Address Register (MAR). IR assembles one instruction from IR_BEATS consecutive bus words on busC, then holds it under a valid/ack handshake to the control unit. MAR is loadable from busC and auto-incrementable. bus_dir drives the memory address from either the MAR or the IR operand field.

Parameters:
DATA_W, 8, width of busC and of one IR beat
ADDR_W, 8, width of MAR, operand and bus_dir; must be ≤ DATA_W and ≤ IR_W-OPC_W
OPC_W, 5, opcode width, taken from the IR MSBs
IR_BEATS, 2, bus beats per instruction (≥1); IR_W = IR_BEATS*DATA_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
busC  in  DATA_W  data bus source for IR beats and MAR load
ena_ir  in  1  store busC as next IR beat
ir_ack  in  1  control unit consumes held instruction
ir_flush  in  1  discard partial/held instruction
hmar  in  1  load MAR from busC[ADDR_W-1:0]
mar_inc  in  1  increment MAR
sel_ir  in  1  bus_dir source: 1 = IR operand, 0 = MAR
opcode  out  OPC_W  IR[IR_W-1 -: OPC_W]
operand  out  ADDR_W  IR[ADDR_W-1:0]
bus_dir  out  ADDR_W  memory address
ir_valid  out  1  full instruction held
beat_cnt  out  clog2(IR_BEATS+1)  beats stored in current assembly
ir_overrun  out  1  sticky: beat offered while IR full and not acked

Behaviour:
- Reset (rst=0, async): IR=0, MAR=0, beat_cnt=0, ir_valid=0, ir_overrun=0; all outputs 0 immediately, without a clock edge.
- States: EMPTY (beat_cnt=0, !ir_valid); ASSEMBLING (0<beat_cnt<IR_BEATS); FULL (ir_valid=1, beat_cnt=0).
- Beat order: first beat goes to the MS slot IR[IR_W-1 -: DATA_W], subsequent beats to descending slots. Only the addressed slot is written; other slots retain old contents.
- Beat load:
  - ena_ir in EMPTY or ASSEMBLING: write slot beat_cnt and increment beat_cnt.
  - On the last beat: ir_valid=1 and beat_cnt=0 at that same edge.
  - Latency: ir_valid rises at the edge that stores beat IR_BEATS.
- FULL:
  - ena_ir without ir_ack: beat ignored, IR unchanged, ir_overrun←1. It stays 1 until reset.
  - ir_ack alone: ir_valid←0, go to EMPTY. IR contents retained.
  - ir_ack and ena_ir together: ack consumes and the beat is stored as beat 0 of the next instruction (beat_cnt=1, ir_valid=0). If IR_BEATS=1, ir_valid stays 1 with the new IR value and no overrun is flagged.
- ir_ack while !ir_valid: no effect.
- ir_flush (synchronous): beat_cnt←0, ir_valid←0, IR contents retained.
  - Priority over ena_ir and ir_ack in the same cycle; that beat is dropped and no overrun is flagged.
- opcode and operand are combinational from the IR register. They reflect partial contents during assembly; consumers qualify them with ir_valid.
- MAR:
  - hmar: MAR←busC[ADDR_W-1:0].
  - else mar_inc: MAR←MAR+1 modulo 2^ADDR_W, so all-ones wraps to 0.
  - hmar has priority when both are asserted.
  - MAR is independent of the IR state machine; loads in any state.
- bus_dir = sel_ir ? operand : MAR, combinational, no register stage.
- Reset asserted mid-assembly discards partial beats. The first beat after reset release goes to slot 0.

Test Plan:
Defaults DATA_W=8, ADDR_W=8, OPC_W=5, IR_BEATS=2, so IR_W=16.
- Reset: hold rst=0 with ena_ir=1, busC=0xFF for 2 cycles → opcode=0, operand=0, bus_dir=0, ir_valid=0, beat_cnt=0, ir_overrun=0.
- Two-beat fetch: ena_ir with busC=0xAA, then 0x3C → after edge 1 beat_cnt=1, ir_valid=0; after edge 2 ir_valid=1, beat_cnt=0, opcode=5'b10101, operand=0x3C; sel_ir=1 → bus_dir=0x3C.
- Overrun and handshake: FULL, ena_ir with busC=0xF0, no ack → IR=0xAA3C unchanged, ir_overrun=1. Then ir_ack alone → ir_valid=0, ir_overrun still 1.
- Ack+load same cycle: FULL with IR=0xAA3C, ir_ack=1 and ena_ir=1 with busC=0x81 → ir_valid=0, beat_cnt=1, IR=0x813C, opcode=5'b10000.
- MAR: hmar with busC=0xFE → bus_dir=0xFE (sel_ir=0). mar_inc ×2 → 0xFF, then 0x00. hmar=1 and mar_inc=1 with busC=0x10 → 0x10.
- Flush/async reset mid-assembly:
  - One beat stored, then ir_flush=1 with ena_ir=1 → beat_cnt=0, no overrun.
  - One beat stored, then rst pulsed low between edges → beat_cnt=0 and outputs 0 before the next edge. Next two beats 0x12, 0x34 → IR=0x1234, ir_valid=1.

Source files
------------

// File: rtl/fetch_mar_ir.sv
// Instruction fetch unit: multi-beat instruction register with a
// valid/ack handshake, plus an auto-incrementing memory address register.
module fetch_mar_ir #(
  parameter  int DATA_W   = 8,
  parameter  int ADDR_W   = 8,
  parameter  int OPC_W    = 5,
  parameter  int IR_BEATS = 2,
  localparam int IR_W     = IR_BEATS * DATA_W,
  localparam int CW       = $clog2(IR_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] busC,
  input  logic              ena_ir,
  input  logic              ir_ack,
  input  logic              ir_flush,
  input  logic              hmar,
  input  logic              mar_inc,
  input  logic              sel_ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] bus_dir,
  output logic              ir_valid,
  output logic [CW-1:0]     beat_cnt,
  output logic              ir_overrun
);

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              val_q, val_d;
  logic              ovr_q, ovr_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              we;
  logic [CW-1:0]     slot;
  logic              last;

  assign last = (cnt_q == CW'(IR_BEATS - 1));

  always_comb begin
    ir_d  = ir_q;
    cnt_d = cnt_q;
    val_d = val_q;
    ovr_d = ovr_q;
    we    = 1'b0;
    slot  = cnt_q;
    if (hmar) begin
      mar_d = busC[ADDR_W-1:0];
    end else if (mar_inc) begin
      mar_d = mar_q + ADDR_W'(1);
    end else begin
      mar_d = mar_q;
    end
    if (ir_flush) begin
      cnt_d = '0;
      val_d = 1'b0;
    end else if (val_q) begin
      if (ena_ir && ir_ack) begin
        // Consume and start the next instruction in one edge
        we    = 1'b1;
        slot  = '0;
        val_d = (IR_BEATS == 1);
        cnt_d = (IR_BEATS == 1) ? '0 : CW'(1);
      end else if (ena_ir) begin
        ovr_d = 1'b1;
      end else if (ir_ack) begin
        val_d = 1'b0;
      end
    end else if (ena_ir) begin
      we = 1'b1;
      if (last) begin
        val_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    for (int i = 0; i < IR_BEATS; i++) begin
      if (we && slot == CW'(i)) begin
        ir_d[(IR_BEATS-i)*DATA_W-1 -: DATA_W] = busC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q  <= '0;
      cnt_q <= '0;
      val_q <= 1'b0;
      ovr_q <= 1'b0;
      mar_q <= '0;
    end else begin
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      ovr_q <= ovr_d;
      mar_q <= mar_d;
    end
  end

  assign opcode     = ir_q[IR_W-1 -: OPC_W];
  assign operand    = ir_q[ADDR_W-1:0];
  assign bus_dir    = sel_ir ? operand : mar_q;
  assign ir_valid   = val_q;
  assign beat_cnt   = cnt_q;
  assign ir_overrun = ovr_q;

endmodule

// File: tb/tb_fetch_mar_ir.sv
// Scoreboard bench for fetch_mar_ir: directed plan then random traffic
// checked against a beat-level reference model.
module tb_fetch_mar_ir;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int OPC_W    = 5;
  localparam int IR_BEATS = 2;
  localparam int IR_W     = IR_BEATS * DATA_W;
  localparam int CW       = $clog2(IR_BEATS + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] busC = '0;
  logic              ena_ir = 1'b0;
  logic              ir_ack = 1'b0;
  logic              ir_flush = 1'b0;
  logic              hmar = 1'b0;
  logic              mar_inc = 1'b0;
  logic              sel_ir = 1'b0;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] bus_dir;
  logic              ir_valid;
  logic [CW-1:0]     beat_cnt;
  logic              ir_overrun;

  fetch_mar_ir #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .OPC_W(OPC_W), .IR_BEATS(IR_BEATS)
  ) dut (
    .clk(clk), .rst(rst), .busC(busC),
    .ena_ir(ena_ir), .ir_ack(ir_ack),
    .ir_flush(ir_flush), .hmar(hmar),
    .mar_inc(mar_inc), .sel_ir(sel_ir),
    .opcode(opcode), .operand(operand),
    .bus_dir(bus_dir), .ir_valid(ir_valid),
    .beat_cnt(beat_cnt), .ir_overrun(ir_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int opc;
    int opd;
    int bdir;
    int val;
    int cnt;
    int ovr;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  event chk_ev;

  longint m_ir;
  int     m_cnt;
  int     m_val;
  int     m_ovr;
  int     m_mar;

  function automatic void model_reset();
    m_ir  = 0;
    m_cnt = 0;
    m_val = 0;
    m_ovr = 0;
    m_mar = 0;
  endfunction

  // Beat k of an instruction lands k slots below the top of the word
  function automatic void put_beat(int k, int d);
    longint sh;
    longint mask;
    sh   = longint'((IR_BEATS - 1 - k) * DATA_W);
    mask = (longint'(1) << DATA_W) - 1;
    m_ir = (m_ir & ~(mask << sh)) | ((longint'(d) & mask) << sh);
  endfunction

  function automatic void model_step(int e, int a, int f,
                                     int h, int inc, int d);
    if (h != 0) m_mar = d % (1 << ADDR_W);
    else if (inc != 0) m_mar = (m_mar + 1) % (1 << ADDR_W);
    if (f != 0) begin
      m_cnt = 0;
      m_val = 0;
    end else if (m_val != 0) begin
      if (a != 0 && e != 0) begin
        put_beat(0, d);
        if (IR_BEATS == 1) begin
          m_val = 1;
          m_cnt = 0;
        end else begin
          m_val = 0;
          m_cnt = 1;
        end
      end else if (e != 0) begin
        m_ovr = 1;
      end else if (a != 0) begin
        m_val = 0;
      end
    end else if (e != 0) begin
      put_beat(m_cnt, d);
      m_cnt++;
      if (m_cnt == IR_BEATS) begin
        m_cnt = 0;
        m_val = 1;
      end
    end
  endfunction

  function automatic exp_t predict(int s);
    exp_t x;
    x.opc  = int'(m_ir >> (IR_W - OPC_W));
    x.opd  = int'(m_ir % (longint'(1) << ADDR_W));
    x.bdir = (s != 0) ? x.opd : m_mar;
    x.val  = m_val;
    x.cnt  = m_cnt;
    x.ovr  = m_ovr;
    return x;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit e, bit a, bit f,
                      bit h, bit inc, bit s, int d);
    @(negedge clk);
    rst      = r;
    ena_ir   = e;
    ir_ack   = a;
    ir_flush = f;
    hmar     = h;
    mar_inc  = inc;
    sel_ir   = s;
    busC     = DATA_W'(d);
    if (!r) model_reset();
    else model_step(int'(e), int'(a), int'(f), int'(h), int'(inc), d);
    q.push_back(predict(int'(s)));
  endtask

  // Reset pulse between edges; outputs must clear without a clock
  task automatic async_rst();
    @(negedge clk);
    ena_ir   = 1'b0;
    ir_ack   = 1'b0;
    ir_flush = 1'b0;
    hmar     = 1'b0;
    mar_inc  = 1'b0;
    sel_ir   = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    q.push_back(predict(1));
    ->chk_ev;
    #2 rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("opcode", int'(opcode), e.opc);
        chk("operand", int'(operand), e.opd);
        chk("bus_dir", int'(bus_dir), e.bdir);
        chk("ir_valid", int'(ir_valid), e.val);
        chk("beat_cnt", int'(beat_cnt), e.cnt);
        chk("ir_overrun", int'(ir_overrun), e.ovr);
      end
    end
  end

  initial begin
    model_reset();
    step(0, 1, 0, 0, 0, 0, 1, 'hFF);
    step(0, 1, 0, 0, 0, 0, 1, 'hFF);
    step(1, 1, 0, 0, 0, 0, 1, 'hAA);
    step(1, 1, 0, 0, 0, 0, 1, 'h3C);
    step(1, 1, 0, 0, 0, 0, 1, 'hF0);
    step(1, 0, 1, 0, 0, 0, 1, 'h00);
    step(1, 1, 0, 0, 0, 0, 1, 'hAA);
    step(1, 1, 0, 0, 0, 0, 1, 'h3C);
    step(1, 1, 1, 0, 0, 0, 1, 'h81);
    step(1, 0, 1, 0, 0, 0, 1, 'h00);
    step(1, 1, 0, 1, 0, 0, 1, 'h77);
    step(1, 0, 0, 0, 1, 0, 0, 'hFE);
    step(1, 0, 0, 0, 0, 1, 0, 'h00);
    step(1, 0, 0, 0, 0, 1, 0, 'h00);
    step(1, 0, 0, 0, 1, 1, 0, 'h10);
    step(1, 1, 0, 0, 0, 0, 1, 'h55);
    async_rst();
    step(1, 1, 0, 0, 0, 0, 1, 'h12);
    step(1, 1, 0, 0, 0, 0, 1, 'h34);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)));
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
